// File: rtl/dpram_port_arbiter.sv
// Two-requester front end for a single dpram: reads and writes from different requesters issue together,
// same-port collisions are settled round-robin, and read data is steered back to its owner two cycles later.
module dpram_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WORD_WIDTH-1:0] m0_wdata_i,
    input  logic [3:0]            m0_wmask_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [WORD_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WORD_WIDTH-1:0] m1_wdata_i,
    input  logic [3:0]            m1_wmask_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [WORD_WIDTH-1:0] m1_rdata_o,

    output logic                  ram_rclke_o,
    output logic                  ram_re_o,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    output logic                  ram_wclke_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [WORD_WIDTH-1:0] ram_wdata_o,
    output logic [3:0]            ram_wbytemask_o,
    input  logic [WORD_WIDTH-1:0] ram_rdata_i
);

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } requester_e;

    logic w_m0Rd;
    logic w_m0Wr;
    logic w_m1Rd;
    logic w_m1Wr;
    logic w_rdGrant;
    logic w_wrGrant;
    requester_e w_rdWinner;
    requester_e w_wrWinner;
    logic [ADDR_WIDTH-1:0] w_rdAddr;
    logic [ADDR_WIDTH-1:0] w_wrAddr;
    logic [WORD_WIDTH-1:0] w_wrData;
    logic [3:0]            w_wrMask;

    requester_e r_rdLast;
    requester_e r_wrLast;

    logic                  r_rdEn;
    logic [ADDR_WIDTH-1:0] r_rdAddr;
    logic                  r_wrEn;
    logic [ADDR_WIDTH-1:0] r_wrAddr;
    logic [WORD_WIDTH-1:0] r_wrData;
    logic [3:0]            r_wrMask;

    logic       r_tag1Valid;
    requester_e r_tag1Owner;
    logic       r_tag2Valid;
    requester_e r_tag2Owner;

    // Each port is arbitrated independently; the last pointer only matters when both want the same port.
    always_comb begin
        w_m0Rd = m0_req_i & ~m0_we_i;
        w_m0Wr = m0_req_i &  m0_we_i;
        w_m1Rd = m1_req_i & ~m1_we_i;
        w_m1Wr = m1_req_i &  m1_we_i;

        w_rdGrant = w_m0Rd | w_m1Rd;
        w_wrGrant = w_m0Wr | w_m1Wr;

        w_rdWinner = REQ_M0;
        if (w_m0Rd && w_m1Rd) begin
            w_rdWinner = (r_rdLast == REQ_M0) ? REQ_M1 : REQ_M0;
        end else if (w_m1Rd) begin
            w_rdWinner = REQ_M1;
        end

        w_wrWinner = REQ_M0;
        if (w_m0Wr && w_m1Wr) begin
            w_wrWinner = (r_wrLast == REQ_M0) ? REQ_M1 : REQ_M0;
        end else if (w_m1Wr) begin
            w_wrWinner = REQ_M1;
        end

        m0_gnt_o = (w_m0Rd && (w_rdWinner == REQ_M0)) || (w_m0Wr && (w_wrWinner == REQ_M0));
        m1_gnt_o = (w_m1Rd && (w_rdWinner == REQ_M1)) || (w_m1Wr && (w_wrWinner == REQ_M1));

        w_rdAddr = (w_rdWinner == REQ_M1) ? m1_addr_i  : m0_addr_i;
        w_wrAddr = (w_wrWinner == REQ_M1) ? m1_addr_i  : m0_addr_i;
        w_wrData = (w_wrWinner == REQ_M1) ? m1_wdata_i : m0_wdata_i;
        w_wrMask = (w_wrWinner == REQ_M1) ? m1_wmask_i : m0_wmask_i;
    end

    // Pointers reset to m1 so that m0 wins the first collision on either port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdLast <= REQ_M1;
            r_wrLast <= REQ_M1;
        end else begin
            if (w_rdGrant) begin
                r_rdLast <= w_rdWinner;
            end
            if (w_wrGrant) begin
                r_wrLast <= w_wrWinner;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdEn   <= 1'b0;
            r_rdAddr <= '0;
        end else begin
            r_rdEn <= w_rdGrant;
            if (w_rdGrant) begin
                r_rdAddr <= w_rdAddr;
            end
        end
    end

    // Address, data and mask hold across idle cycles; only the enables drop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_wrMask <= '0;
        end else begin
            r_wrEn <= w_wrGrant;
            if (w_wrGrant) begin
                r_wrAddr <= w_wrAddr;
                r_wrData <= w_wrData;
                r_wrMask <= w_wrMask;
            end
        end
    end

    // Stage 1 lines up with the read command, stage 2 with the dpram's registered read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tag1Valid <= 1'b0;
            r_tag1Owner <= REQ_M0;
            r_tag2Valid <= 1'b0;
            r_tag2Owner <= REQ_M0;
        end else begin
            r_tag1Valid <= w_rdGrant;
            r_tag1Owner <= w_rdWinner;
            r_tag2Valid <= r_tag1Valid;
            r_tag2Owner <= r_tag1Owner;
        end
    end

    always_comb begin
        ram_rclke_o     = r_rdEn;
        ram_re_o        = r_rdEn;
        ram_raddr_o     = r_rdAddr;
        ram_wclke_o     = r_wrEn;
        ram_we_o        = r_wrEn;
        ram_waddr_o     = r_wrAddr;
        ram_wdata_o     = r_wrData;
        ram_wbytemask_o = r_wrMask;

        m0_rvalid_o = r_tag2Valid && (r_tag2Owner == REQ_M0);
        m1_rvalid_o = r_tag2Valid && (r_tag2Owner == REQ_M1);
        m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: a behavioural read-before-write dpram behind the DUT, an independent
// arbitration/memory model predicting grants, and a scoreboard queue matching read returns.
module tb_dpram_port_arbiter;

    localparam int AW = 9;
    localparam int WW = 32;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        logic [3:0]    mask;
    } cmd_t;

    typedef struct {
        bit            owner;
        logic [WW-1:0] data;
        int            due;
    } sbEntry_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_req_i, m0_we_i, m0_gnt_o, m0_rvalid_o;
    logic [AW-1:0] m0_addr_i;
    logic [WW-1:0] m0_wdata_i, m0_rdata_o;
    logic [3:0]    m0_wmask_i;
    logic          m1_req_i, m1_we_i, m1_gnt_o, m1_rvalid_o;
    logic [AW-1:0] m1_addr_i;
    logic [WW-1:0] m1_wdata_i, m1_rdata_o;
    logic [3:0]    m1_wmask_i;
    logic          ram_rclke_o, ram_re_o, ram_wclke_o, ram_we_o;
    logic [AW-1:0] ram_raddr_o, ram_waddr_o;
    logic [WW-1:0] ram_wdata_o, ram_rdata_i;
    logic [3:0]    ram_wbytemask_o;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    bit [WW-1:0] ramMem [0:(1<<AW)-1];
    bit [WW-1:0] shadow [0:(1<<AW)-1];
    bit          rdLast;
    bit          wrLast;
    sbEntry_t    sb[$];

    always #5 clk_i = ~clk_i;

    dpram_port_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_wmask_i(m0_wmask_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_wmask_i(m1_wmask_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_rclke_o(ram_rclke_o), .ram_re_o(ram_re_o), .ram_raddr_o(ram_raddr_o),
        .ram_wclke_o(ram_wclke_o), .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o),
        .ram_wdata_o(ram_wdata_o), .ram_wbytemask_o(ram_wbytemask_o), .ram_rdata_i(ram_rdata_i)
    );

    // Behavioural dpram: registered read, byte-masked write, read-before-write on a shared address.
    always @(posedge clk_i) begin
        if (ram_rclke_o && ram_re_o) begin
            ram_rdata_i <= ramMem[ram_raddr_o];
        end
        if (ram_wclke_o && ram_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wbytemask_o[b]) begin
                    ramMem[ram_waddr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic cmd_t idleCmd();
        cmd_t c;
        c = '0;
        return c;
    endfunction

    function automatic cmd_t rdCmd(input logic [AW-1:0] addr);
        cmd_t c;
        c = '0;
        c.req = 1'b1;
        c.addr = addr;
        return c;
    endfunction

    function automatic cmd_t wrCmd(input logic [AW-1:0] addr, input logic [WW-1:0] data, input logic [3:0] mask);
        cmd_t c;
        c.req = 1'b1;
        c.we = 1'b1;
        c.addr = addr;
        c.wdata = data;
        c.mask = mask;
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s @cycle %0d: actual=%h expected=%h", tag, cycle, actual, expected);
        end
    endtask

    task automatic checkReturns();
        sbEntry_t e;
        logic exp0, exp1;
        exp0 = 1'b0;
        exp1 = 1'b0;
        e.owner = 1'b0;
        e.data = '0;
        e.due = 0;
        if (sb.size() > 0 && sb[0].due == cycle) begin
            e = sb.pop_front();
            if (e.owner) exp1 = 1'b1;
            else         exp0 = 1'b1;
        end
        checkOutput("m0_rvalid", 32'(m0_rvalid_o), 32'(exp0));
        checkOutput("m1_rvalid", 32'(m1_rvalid_o), 32'(exp1));
        if (exp0) checkOutput("m0_rdata", m0_rdata_o, e.data);
        if (exp1) checkOutput("m1_rdata", m1_rdata_o, e.data);
    endtask

    task automatic checkResetState();
        checkOutput("rst_m0_gnt", 32'(m0_gnt_o), 0);
        checkOutput("rst_m1_gnt", 32'(m1_gnt_o), 0);
        checkOutput("rst_m0_rvalid", 32'(m0_rvalid_o), 0);
        checkOutput("rst_m1_rvalid", 32'(m1_rvalid_o), 0);
        checkOutput("rst_ram_rclke", 32'(ram_rclke_o), 0);
        checkOutput("rst_ram_re", 32'(ram_re_o), 0);
        checkOutput("rst_ram_raddr", 32'(ram_raddr_o), 0);
        checkOutput("rst_ram_wclke", 32'(ram_wclke_o), 0);
        checkOutput("rst_ram_we", 32'(ram_we_o), 0);
        checkOutput("rst_ram_waddr", 32'(ram_waddr_o), 0);
        checkOutput("rst_ram_wdata", ram_wdata_o, 0);
        checkOutput("rst_ram_wbytemask", 32'(ram_wbytemask_o), 0);
    endtask

    // Called at a negedge; drives one cycle of stimulus, checks grants and advances to the next negedge.
    task automatic applyStimulus(input cmd_t c0, input cmd_t c1, input logic rst);
        logic r0, r1, w0, w1, g0, g1;
        bit rdW, wrW;
        cmd_t cw;
        sbEntry_t e;
        checkReturns();
        rst_i = rst;
        m0_req_i = c0.req; m0_we_i = c0.we; m0_addr_i = c0.addr; m0_wdata_i = c0.wdata; m0_wmask_i = c0.mask;
        m1_req_i = c1.req; m1_we_i = c1.we; m1_addr_i = c1.addr; m1_wdata_i = c1.wdata; m1_wmask_i = c1.mask;
        #1;
        r0 = c0.req && !c0.we;
        w0 = c0.req && c0.we;
        r1 = c1.req && !c1.we;
        w1 = c1.req && c1.we;
        rdW = (r0 && r1) ? !rdLast : r1;
        wrW = (w0 && w1) ? !wrLast : w1;
        g0 = (r0 && !rdW) || (w0 && !wrW);
        g1 = (r1 && rdW) || (w1 && wrW);
        checkOutput("m0_gnt", 32'(m0_gnt_o), 32'(g0));
        checkOutput("m1_gnt", 32'(m1_gnt_o), 32'(g1));
        if (rst) begin
            sb.delete();
            rdLast = 1'b1;
            wrLast = 1'b1;
        end else begin
            if (r0 || r1) begin
                e.owner = rdW;
                e.data = shadow[rdW ? c1.addr : c0.addr];
                e.due = cycle + 2;
                sb.push_back(e);
                rdLast = rdW;
            end
            if (w0 || w1) begin
                cw = wrW ? c1 : c0;
                for (int b = 0; b < 4; b++) begin
                    if (cw.mask[b]) shadow[cw.addr][8*b +: 8] = cw.wdata[8*b +: 8];
                end
                wrLast = wrW;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cycle++;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(idleCmd(), idleCmd(), 1'b0);
    endtask

    initial begin
        rst_i = 1'b1;
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0; m0_wmask_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0; m1_wmask_i = '0;
        rdLast = 1'b1;
        wrLast = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        checkResetState();

        $display("[TB] write then read of addr 5");
        applyStimulus(wrCmd(9'd5, 32'hDEADBEEF, 4'hF), idleCmd(), 1'b0);
        checkOutput("t1_ram_we", 32'(ram_we_o), 1);
        checkOutput("t1_ram_wclke", 32'(ram_wclke_o), 1);
        checkOutput("t1_ram_waddr", 32'(ram_waddr_o), 5);
        checkOutput("t1_ram_wdata", ram_wdata_o, 32'hDEADBEEF);
        checkOutput("t1_ram_wbytemask", 32'(ram_wbytemask_o), 32'hF);
        applyStimulus(idleCmd(), idleCmd(), 1'b0);
        checkOutput("t1_ram_we_idle", 32'(ram_we_o), 0);
        checkOutput("t1_ram_waddr_hold", 32'(ram_waddr_o), 5);
        applyStimulus(idleCmd(), rdCmd(9'd5), 1'b0);
        checkOutput("t1_ram_re", 32'(ram_re_o), 1);
        checkOutput("t1_ram_raddr", 32'(ram_raddr_o), 5);
        runIdle(3);

        $display("[TB] read contention on both requesters");
        applyStimulus(wrCmd(9'd1, 32'h01010101, 4'hF), idleCmd(), 1'b0);
        applyStimulus(idleCmd(), wrCmd(9'd2, 32'h02020202, 4'hF), 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(rdCmd(9'd1), rdCmd(9'd2), 1'b0);
        runIdle(3);

        $display("[TB] same-cycle read/write hazard on addr 7");
        applyStimulus(wrCmd(9'd7, 32'hCAFEF00D, 4'hF), rdCmd(9'd7), 1'b0);
        applyStimulus(idleCmd(), rdCmd(9'd7), 1'b0);
        runIdle(3);

        $display("[TB] byte mask merge on addr 3");
        applyStimulus(wrCmd(9'd3, 32'h11223344, 4'hF), idleCmd(), 1'b0);
        applyStimulus(idleCmd(), wrCmd(9'd3, 32'hAABBCCDD, 4'b0101), 1'b0);
        applyStimulus(wrCmd(9'd3, 32'hFFFFFFFF, 4'b0000), rdCmd(9'd3), 1'b0);
        applyStimulus(idleCmd(), rdCmd(9'd3), 1'b0);
        runIdle(3);

        $display("[TB] reset with a read in flight");
        applyStimulus(rdCmd(9'd1), idleCmd(), 1'b0);
        applyStimulus(idleCmd(), idleCmd(), 1'b1);
        checkResetState();
        applyStimulus(idleCmd(), idleCmd(), 1'b0);
        applyStimulus(rdCmd(9'd4), rdCmd(9'd5), 1'b0);
        applyStimulus(idleCmd(), rdCmd(9'd5), 1'b0);
        runIdle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one dpram instance between two requesters, m0 and m1, on a single clock domain.
- Routes each granted read to the dpram read port and each granted write to the dpram write port.
- A read from one requester and a write from the other are issued in the same cycle.
- Round-robin arbitration applies only when both requesters need the same port. All dpram-side signals are registered.

Parameters:
ADDR_WIDTH, 9, dpram address width
WORD_WIDTH, 32, data width; fixed at 32 because of the 4-bit byte mask

Ports:
clk_i  in  1  clock; also drives dpram rclk_i and wclk_i externally
rst_i  in  1  synchronous active-high reset
m0_req_i  in  1  m0 request; held until m0_gnt_o
m0_we_i  in  1  1=write, 0=read
m0_addr_i  in  ADDR_WIDTH  word address
m0_wdata_i  in  WORD_WIDTH  write data
m0_wmask_i  in  4  byte mask, bit n enables byte n
m0_gnt_o  out  1  request accepted this cycle
m0_rvalid_o  out  1  read data valid
m0_rdata_o  out  WORD_WIDTH  read data
m1_*  same set as m0_*
ram_rclke_o  out  1  to dpram rclke_i
ram_re_o  out  1  to dpram re_i
ram_raddr_o  out  ADDR_WIDTH  to dpram raddr_i
ram_wclke_o  out  1  to dpram wclke_i
ram_we_o  out  1  to dpram we_i
ram_waddr_o  out  ADDR_WIDTH  to dpram waddr_i
ram_wdata_o  out  WORD_WIDTH  to dpram wdata_i
ram_wbytemask_o  out  4  to dpram wbytemask_i
ram_rdata_i  in  WORD_WIDTH  from dpram rdata_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state:
  - All registered outputs are 0.
  - Round-robin pointers rd_last and wr_last reset to 1, so m0 wins the first contention on each port.
  - The read-tag pipeline is cleared.
- Grant (combinational within cycle N):
  - Each active request targets the read port (we=0) or the write port (we=1).
  - Different ports: both requesters are granted in the same cycle.
  - Same port, both requesting: the winner is the requester not named in that port's last pointer. The pointer updates to the winner at the clock edge.
  - Single requester on a port: granted immediately; that port's pointer updates to it.
  - gnt_o is high for exactly the cycles in which a request is accepted. A requester keeping req high after gnt issues a new request each cycle.
- Command stage (registered, edge at end of N; ram_* valid in cycle N+1):
  - Granted write: ram_wclke_o=ram_we_o=1; ram_waddr_o, ram_wdata_o and ram_wbytemask_o come from the winner.
  - Granted read: ram_rclke_o=ram_re_o=1 and ram_raddr_o=winner address. Read tag (valid, owner) enters stage 1.
  - No grant on a port: that port's clke/enable are 0. Address and data hold their previous values.
- Read return:
  - dpram captures the read at the end of N+1.
  - In cycle N+2, the tag reaches stage 2. The owner's rvalid_o is high for one cycle, and rdata_o equals ram_rdata_i (pass-through). The other requester's rvalid_o stays 0.
  - rdata_o of a requester with rvalid_o=0 is don't-care; the implementation holds 0.
- Latency and throughput:
  - Read latency is 2 cycles from grant to rvalid.
  - Throughput is one read plus one write per cycle.
- Hazards:
  - Read and write to the same address granted in the same cycle: the read returns the old data (dpram read-before-write).
  - Write granted in N, read of the same address granted in N+1 or later: the read returns the new data.
- Write mask: a mask of 4'b0000 is still granted and issued; memory is unchanged. The mask is ignored for reads.
- Reset mid-operation: in-flight read tags are discarded and no rvalid_o follows. Commands already presented to the dpram at the reset edge are not cancelled.

Test Plan:
1. Reset, then m0 writes addr 5 = 32'hDEADBEEF, mask 4'hF; m1 reads addr 5 two cycles later -> m1_gnt_o the same cycle as the request; m1_rvalid_o 2 cycles after grant with 32'hDEADBEEF.
2. Both requesters read every cycle (m0 addr 1, m1 addr 2) for 6 cycles -> grants alternate m0, m1, m0, …; rvalid alternates with the correct data; no cycle has both rvalid_o high.
3. m0 writes addr 7 while m1 reads addr 7 in the same cycle (prior content 32'h0) -> both granted; m1 reads 32'h0. m1 reads addr 7 again the next cycle -> new value.
4. Write 32'h11223344 to addr 3, then 32'hAABBCCDD with mask 4'b0101 -> a read of addr 3 returns 32'h11BB33DD.
5. m0 issues a read; rst_i asserted the next cycle for 1 cycle -> no m0_rvalid_o; all ram_*/gnt outputs 0 after reset; the next contention is won by m0.
